// File: rtl/data_memory_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
package data_memory_responder_pkg;

  // Default geometry and timing
  localparam int DEPTH_LOG_DEF = 10;
  localparam int LATENCY_DEF   = 1;
  localparam int NUM_LANES     = 4;
  localparam int CNT_W         = 4;

  // Request and response as seen on the core's data-memory port
  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic {IDLE, BUSY} state_type;

  typedef struct packed {
    state_type        state;
    logic [CNT_W-1:0] cnt;
    logic             ready;
    logic             load;
  } reg_type;

  localparam reg_type REG_INIT = '{state: IDLE, cnt: '0, ready: 1'b0, load: 1'b0};

endpackage

// File: rtl/data_memory_responder_ram.sv
// Single-port word SRAM built from one byte-wide array per lane so each lane
// maps onto its own block RAM with a plain write enable.
import data_memory_responder_pkg::*;

module data_memory_ram #(
  parameter int DEPTH_LOG = DEPTH_LOG_DEF
) (
  input  logic                                clk,
  input  logic                                re,
  input  logic [NUM_LANES-1:0]                we,
  input  logic [DEPTH_LOG-1:0]                addr,
  input  logic [NUM_LANES-1:0][7:0]           wdata,
  output logic [NUM_LANES-1:0][7:0]           rdata
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0] mem [0:(2**DEPTH_LOG)-1];
    logic [7:0] q;

    // Byte-lane write and registered read; read only fires on loads
    always_ff @(posedge clk) begin
      if (we[g]) mem[addr] <= wdata[g];
      if (re)    q         <= mem[addr];
    end

    assign rdata[g] = q;
  end

endmodule

// File: rtl/data_memory_responder.sv
// Responder for the core's data-memory port: fixed-latency load/store service
// from an internal byte-enabled SRAM.
import data_memory_responder_pkg::*;

module data_memory_responder #(
  parameter int DEPTH_LOG = DEPTH_LOG_DEF,
  parameter int LATENCY   = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  reg_type                     r;
  logic                        accept;
  logic                        is_load;
  logic [NUM_LANES-1:0]        ram_we;
  logic [NUM_LANES-1:0][7:0]   ram_q;
  logic                        unused_bits;

  // A request is taken when idle or in the response cycle; anything else is dropped
  assign accept  = rst && dmem_in.mem_valid &&
                   (r.state == IDLE || r.cnt == '0);
  assign is_load = (dmem_in.mem_wstrb == 4'b0000);
  assign ram_we  = accept ? dmem_in.mem_wstrb : '0;

  // Offset and high address bits alias; instr flag is carried only for type compatibility
  assign unused_bits = ^{dmem_in.mem_instr, dmem_in.mem_addr[31:DEPTH_LOG+2],
                         dmem_in.mem_addr[1:0]};

  data_memory_ram #(.DEPTH_LOG(DEPTH_LOG)) u_ram (
    .clk   (clk),
    .re    (accept && is_load),
    .we    (ram_we),
    .addr  (dmem_in.mem_addr[DEPTH_LOG+1:2]),
    .wdata (dmem_in.mem_wdata),
    .rdata (ram_q)
  );

  // FSM: count down the wait cycles, raise ready for the final one
  always_ff @(posedge clk) begin
    if (!rst) begin
      r <= REG_INIT;
    end else begin
      r.ready <= 1'b0;
      if (accept) begin
        r.state <= BUSY;
        r.cnt   <= CNT_LOAD;
        r.ready <= (CNT_LOAD == '0);
        r.load  <= is_load;
      end else if (r.state == BUSY) begin
        if (r.cnt != '0) begin
          r.cnt   <= r.cnt - 1'b1;
          r.ready <= (r.cnt == CNT_W'(1));
        end else begin
          r.state <= IDLE;
        end
      end
    end
  end

  // Response built only from registers; the SRAM word register holds until the next load
  assign dmem_out.mem_ready = r.ready;
  assign dmem_out.mem_rdata = (r.ready && r.load) ? ram_q : 32'h0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder; four latency variants share one stimulus.
import data_memory_responder_pkg::*;

module tb_data_memory_responder;

  logic        clk;
  logic        rst;
  mem_in_type  din;
  mem_out_type out1, out2, out3, out4;

  int n_chk  = 0;
  int n_pass = 0;

  data_memory_responder #(.DEPTH_LOG(10), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .dmem_in(din), .dmem_out(out1));
  data_memory_responder #(.DEPTH_LOG(10), .LATENCY(2)) u2 (.clk(clk), .rst(rst), .dmem_in(din), .dmem_out(out2));
  data_memory_responder #(.DEPTH_LOG(10), .LATENCY(3)) u3 (.clk(clk), .rst(rst), .dmem_in(din), .dmem_out(out3));
  data_memory_responder #(.DEPTH_LOG(10), .LATENCY(4)) u4 (.clk(clk), .rst(rst), .dmem_in(din), .dmem_out(out4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one cycle; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    din.mem_valid = 1'b1;
    din.mem_addr  = addr;
    din.mem_wdata = wdata;
    din.mem_wstrb = wstrb;
  endtask

  task automatic idle();
    din.mem_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    idle();
    repeat (n) step();
  endtask

  // One LATENCY=1 transaction: ready must appear the cycle after the request
  task automatic l1_xact(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] exp);
    drive(addr, wdata, wstrb);
    step();
    idle();
    chk({tag, "_rdy"}, 32'(out1.mem_ready), 32'd1);
    chk({tag, "_data"}, out1.mem_rdata, exp);
    step();
  endtask

  initial begin
    int cnt;
    int lat;
    rst = 1'b0;
    din = '0;
    repeat (2) step();

    // Reset state
    chk("rst_rdy1", 32'(out1.mem_ready), 32'd0);
    chk("rst_dat1", out1.mem_rdata, 32'h0);
    chk("rst_rdy4", 32'(out4.mem_ready), 32'd0);
    chk("rst_dat4", out4.mem_rdata, 32'h0);
    rst = 1'b1;
    step();

    // LATENCY=1 store then load
    drive(32'h10, 32'hDEADBEEF, 4'b1111);
    step();
    idle();
    chk("st_rdy", 32'(out1.mem_ready), 32'd1);
    chk("st_data", out1.mem_rdata, 32'h0);
    drive(32'h10, 32'h0, 4'b0000);
    step();
    idle();
    chk("ld_rdy", 32'(out1.mem_ready), 32'd1);
    chk("ld_data", out1.mem_rdata, 32'hDEADBEEF);
    step();
    chk("ld_rdy_off", 32'(out1.mem_ready), 32'd0);
    chk("ld_data_off", out1.mem_rdata, 32'h0);
    gap(6);

    // Byte lanes with ignored offset bits
    l1_xact("pre", 32'h20, 32'h11223344, 4'b1111, 32'h0);
    l1_xact("lane", 32'h20, 32'h0000AA00, 4'b0010, 32'h0);
    l1_xact("lane_ld", 32'h22, 32'h0, 4'b0000, 32'h1122AA44);
    gap(6);

    // Aliasing above the word index
    l1_xact("al_st", 32'h0000_0004, 32'hCAFEF00D, 4'b1111, 32'h0);
    l1_xact("al_ld", 32'h0000_1004, 32'h0, 4'b0000, 32'hCAFEF00D);
    gap(6);

    // Back-to-back at LATENCY=2: requests at c0, c2, c4
    drive(32'h40, 32'h0BADC0DE, 4'b1111);
    step(); idle();
    chk("b2b_c1", 32'(out2.mem_ready), 32'd0);
    step();
    chk("b2b_c2", 32'(out2.mem_ready), 32'd1);
    chk("b2b_c2d", out2.mem_rdata, 32'h0);
    drive(32'h40, 32'h0, 4'b0000);
    step(); idle();
    chk("b2b_c3", 32'(out2.mem_ready), 32'd0);
    chk("b2b_c3d", out2.mem_rdata, 32'h0);
    step();
    chk("b2b_c4", 32'(out2.mem_ready), 32'd1);
    chk("b2b_c4d", out2.mem_rdata, 32'h0BADC0DE);
    drive(32'h40, 32'h0, 4'b0000);
    step(); idle();
    chk("b2b_c5", 32'(out2.mem_ready), 32'd0);
    step();
    chk("b2b_c6", 32'(out2.mem_ready), 32'd1);
    chk("b2b_c6d", out2.mem_rdata, 32'h0BADC0DE);
    step();
    chk("b2b_c7", 32'(out2.mem_ready), 32'd0);
    gap(6);

    // LATENCY=4 with a dropped request mid-wait (c10 request, c12 drop)
    drive(32'h40, 32'h0, 4'b0000);
    step(); idle();
    chk("l4_c11", 32'(out4.mem_ready), 32'd0);
    step();
    chk("l4_c12", 32'(out4.mem_ready), 32'd0);
    drive(32'h40, 32'h0, 4'b0000);
    step(); idle();
    chk("l4_c13", 32'(out4.mem_ready), 32'd0);
    chk("l4_c13d", out4.mem_rdata, 32'h0);
    step();
    chk("l4_c14", 32'(out4.mem_ready), 32'd1);
    chk("l4_c14d", out4.mem_rdata, 32'h0BADC0DE);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out4.mem_ready) cnt++;
    end
    chk("l4_one_pulse", 32'(cnt), 32'd0);
    gap(6);

    // Reset one cycle after a LATENCY=3 store is accepted
    drive(32'h30, 32'h5A5A1234, 4'b1111);
    step(); idle();
    chk("rm_c1", 32'(out3.mem_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("rm_rdy", 32'(out3.mem_ready), 32'd0);
    chk("rm_dat", out3.mem_rdata, 32'h0);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out3.mem_ready || out3.mem_rdata != 32'h0) cnt++;
    end
    chk("rm_no_rdy", 32'(cnt), 32'd0);

    // Stored word survives the reset; bounded wait for the response
    drive(32'h30, 32'h0, 4'b0000);
    step(); idle();
    lat = 1;
    while (!out3.mem_ready && lat < 8) begin
      step();
      lat++;
    end
    chk("rm_ld_lat", 32'(lat), 32'd3);
    chk("rm_ld_data", out3.mem_rdata, 32'h5A5A1234);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the core's data-memory interface. It accepts load/store requests from the memory-access side of the pipeline, services them from an internal byte-enabled word SRAM after a programmable number of wait cycles, and returns the mem_ready/mem_rdata response that the execute stage stalls on. It sits between the core and the memory map as the default tightly-coupled data RAM.

## Interface
- DEPTH_LOG, 10: log2 of SRAM depth in 32-bit words (default 1024 words = 4 KiB).
- LATENCY, 1: cycles from request acceptance to mem_ready pulse; legal range 1..15.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- dmem_in.mem_valid  in  1  request strobe, one cycle per request.
- dmem_in.mem_instr  in  1  instruction-fetch flag; ignored by this block, carried for type compatibility.
- dmem_in.mem_addr  in  32  byte address.
- dmem_in.mem_wdata  in  32  store data, byte lanes aligned to address.
- dmem_in.mem_wstrb  in  4  byte write enables; 0000 = load.
- dmem_out.mem_ready  out  1  one-cycle response strobe.
- dmem_out.mem_rdata  out  32  full word read data, valid only with mem_ready.

## Operation
- State machine: IDLE, BUSY.
- IDLE: mem_valid=1 -> accept. Latch kind (load/store), set counter cnt = LATENCY-1, go BUSY.
- On the acceptance edge:
  - Word index = mem_addr[DEPTH_LOG+1:2]. Bits [1:0] are ignored. Address bits above the index alias, with no error.
  - Store: write each lane i with wstrb[i]=1 into the SRAM.
  - Load: register the SRAM word into the response register.
- BUSY, cnt!=0: decrement cnt. mem_ready=0. mem_valid is ignored, because a request while busy is a protocol violation and is dropped.
- BUSY, cnt==0: mem_ready=1 for exactly one cycle.
  - Load: mem_rdata = registered word.
  - Store: mem_rdata = 0.
  - If mem_valid=1 in this same cycle, accept it (back-to-back) and stay BUSY with the counter reloaded. Otherwise go IDLE.
- Read-after-write: a store accepted at edge N is visible to a load accepted at edge N+k for any k>=1.
- Lane extraction and sign extension are not done here; they belong to lsu. mem_rdata is always the whole word.
- mem_rdata is 0 whenever mem_ready=0.

## Timing
- Reset: state=IDLE, cnt=0, mem_ready=0, mem_rdata=0. SRAM contents are not cleared.
- Reset asserted mid-BUSY abandons the pending request and no mem_ready is produced. A store already accepted stays written.
- Latency: request at cycle T (mem_valid high in IDLE) -> mem_ready high at cycle T+LATENCY, low at T+LATENCY+1 unless a back-to-back request follows.
- Throughput: one request per LATENCY cycles when back-to-back. LATENCY=1 gives one per cycle.
- All outputs are registered. There is no combinational path from dmem_in to dmem_out.

## Structure
- Shared package (wires) holds the typedefs:
  - mem_in_type {mem_valid, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]}
  - mem_out_type {mem_ready, mem_rdata[31:0]}
  - the responder state enum and its register struct with init constant
- Shared package (constants) holds the default DEPTH_LOG/LATENCY values.
- Sub-module data_memory_ram: single-port 2^DEPTH_LOG x 32 SRAM with 4 byte write enables and a synchronous read port, written for block-RAM inference.
- The top holds the FSM, counter and response register.

## Test plan
- LATENCY=1, store addr 0x10 wdata 0xDEADBEEF wstrb 1111, then load 0x10 -> store ready at T+1 with rdata 0; load ready one cycle after its request with rdata 0xDEADBEEF.
- Byte lanes: preload 0x11223344 at 0x20, store wdata 0x0000AA00 wstrb 0010, load 0x22 -> rdata 0x1122AA44 (offset bits ignored).
- LATENCY=4: load request at cycle 10 -> mem_ready low at cycles 11-13 and high only at 14; a mem_valid at cycle 12 is dropped (exactly one ready pulse).
- Back-to-back, LATENCY=2: requests at cycles 0, 2, 4 (each coinciding with the previous ready) -> ready at cycles 2, 4, 6 with correct data; FSM never returns to IDLE in between.
- Aliasing, DEPTH_LOG=10: store 0xCAFEF00D at 0x0000_0004, load 0x0000_1004 -> rdata 0xCAFEF00D.
- Reset mid-op, LATENCY=3: store to 0x30 accepted, rst=0 one cycle later -> no mem_ready ever, outputs 0; after reset a load of 0x30 returns the stored data.
